// File: rtl/apogeo_pkg.sv
// -----------------------------------------------------------------------------
// apogeo_pkg
// Shared types for the load path: data word, load micro-op, access width,
// load queue entry, private address region bounds and small decode helpers.
// -----------------------------------------------------------------------------
package apogeo_pkg;

    typedef logic [31:0] data_word_t;

    typedef enum logic [1:0] {
        LDB = 2'b00,
        LDH = 2'b01,
        LDW = 2'b10
    } ldu_op_t;

    typedef struct packed {
        ldu_op_t uop;
        logic    signed_load;
    } ldu_uop_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10
    } store_width_t;

    localparam data_word_t PRIVATE_REGION_START = 32'h8000_0000;
    localparam data_word_t PRIVATE_REGION_END   = 32'h8000_FFFF;

    typedef struct packed {
        logic       valid;
        ldu_op_t    uop;
        logic       signed_load;
        logic [1:0] offset;
        logic       misaligned;
        logic       illegal;
        logic       mem_pending;
        logic       done;
        data_word_t data;
    } load_queue_entry_t;

    function automatic store_width_t uop_to_width(input ldu_op_t op);
        unique case (op)
            LDB:     return WIDTH_BYTE;
            LDH:     return WIDTH_HALF;
            default: return WIDTH_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input ldu_op_t op, input logic [1:0] off);
        unique case (op)
            LDB:     return 1'b0;
            LDH:     return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_interface.sv
// -----------------------------------------------------------------------------
// load_interface
// Memory load channel: request/address from the load unit, valid/data back
// from memory (responses return in request order).
// -----------------------------------------------------------------------------
interface load_interface;
    logic                   request;
    apogeo_pkg::data_word_t address;
    logic                   valid;
    apogeo_pkg::data_word_t data;

    modport master(output request, output address, input valid, input data);
    modport slave (input request, input address, output valid, output data);
endinterface

// File: rtl/load_data_slicer.sv
// -----------------------------------------------------------------------------
// load_data_slicer
// Combinational byte/halfword selection and sign/zero extension of a loaded
// word.
// Ports: uop_i (load kind), signed_i (sign-extend), offset_i (address[1:0]),
//        data_i (raw word), data_o (extended result).
// -----------------------------------------------------------------------------
module load_data_slicer
    import apogeo_pkg::*;
(
    input  ldu_op_t    uop_i,
    input  logic       signed_i,
    input  logic [1:0] offset_i,
    input  data_word_t data_i,
    output data_word_t data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (offset_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

        unique case (uop_i)
            LDB:     data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            LDH:     data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_queue_unit.sv
// -----------------------------------------------------------------------------
// load_queue_unit
// In-order load queue: accepts load ops, checks alignment/privilege, optionally
// takes store-buffer forwarded data, issues memory requests, fills entries from
// in-order memory responses and retires results in program order.
// Optional feature: define LOAD_QUEUE_FORWARDING_EN to use foward_match_i /
// foward_data_i; otherwise every legal op goes to memory.
// Ports: clk_i, rst_n_i (async active-low), stall_i, privilege_i (1=machine),
//        valid_operation_i/operation_i/load_address_i (op in), ready_o,
//        load_channel (memory master), foward_match_i/foward_data_i,
//        load_size_o, buffer_wait_i, data_loaded_o/data_valid_o/misaligned_o/
//        illegal_access_o (retire result), idle_o.
// -----------------------------------------------------------------------------
module load_queue_unit
    import apogeo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 stall_i,
    input  logic                 privilege_i,
    input  logic                 valid_operation_i,
    input  ldu_uop_t             operation_i,
    input  data_word_t           load_address_i,
    output logic                 ready_o,
    load_interface.master        load_channel,
    input  logic                 foward_match_i,
    input  data_word_t           foward_data_i,
    output store_width_t         load_size_o,
    input  logic                 buffer_wait_i,
    output data_word_t           data_loaded_o,
    output logic                 data_valid_o,
    output logic                 misaligned_o,
    output logic                 illegal_access_o,
    output logic                 idle_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    load_queue_entry_t entries_q [DEPTH];
    load_queue_entry_t entries_d [DEPTH];
    load_queue_entry_t head_entry;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, mem_ptr, scan_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_found, resp_fill, retire;
    logic              accept, misaligned, illegal, exception, fwd_hit, need_mem;
    data_word_t        acc_data, sliced_data;
    data_word_t        data_loaded_q, data_loaded_d;
    logic              data_valid_q, data_valid_d;
    logic              misaligned_q, misaligned_d, illegal_q, illegal_d;

`ifdef LOAD_QUEUE_FORWARDING_EN
    assign fwd_hit = foward_match_i;
`else
    logic unused_fwd;
    assign unused_fwd = ^{foward_match_i, foward_data_i};
    assign fwd_hit    = 1'b0;
`endif

    assign ready_o    = (count_q < DEPTH_C) & ~buffer_wait_i;
    assign accept     = valid_operation_i & ready_o;
    assign misaligned = is_misaligned(operation_i.uop, load_address_i[1:0]);
    assign illegal    = ~privilege_i & (load_address_i >= PRIVATE_REGION_START)
                                     & (load_address_i <= PRIVATE_REGION_END);
    assign exception  = misaligned | illegal;
    assign need_mem   = accept & ~exception & ~fwd_hit;
    assign acc_data   = (!exception && fwd_hit) ? foward_data_i : '0;

    assign load_channel.request = need_mem;
    assign load_channel.address = load_address_i;
    assign load_size_o          = uop_to_width(operation_i.uop);

    // Valid entries are contiguous from head, so the first memory-pending one
    // found scanning from head is the oldest outstanding request.
    always_comb begin
        mem_found = 1'b0;
        mem_ptr   = head_q;
        scan_idx  = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!mem_found && entries_q[scan_idx].valid && entries_q[scan_idx].mem_pending) begin
                mem_found = 1'b1;
                mem_ptr   = scan_idx;
            end
        end
    end

    assign resp_fill = load_channel.valid & mem_found;

    // Fills and allocation are applied before the head is examined, so an
    // entry completed this cycle at the head retires in the same cycle.
    always_comb begin
        entries_d = entries_q;
        if (resp_fill) begin
            entries_d[mem_ptr].data        = load_channel.data;
            entries_d[mem_ptr].done        = 1'b1;
            entries_d[mem_ptr].mem_pending = 1'b0;
        end
        if (accept) begin
            entries_d[tail_q] = '{valid: 1'b1, uop: operation_i.uop,
                                  signed_load: operation_i.signed_load,
                                  offset: load_address_i[1:0], misaligned: misaligned,
                                  illegal: illegal, mem_pending: need_mem,
                                  done: ~need_mem, data: acc_data};
        end
        head_entry = entries_d[head_q];
        retire     = head_entry.valid & head_entry.done & ~stall_i;
        if (retire) begin
            entries_d[head_q].valid = 1'b0;
        end
    end

    assign head_d  = head_q + PTR_W'(retire);
    assign tail_d  = tail_q + PTR_W'(accept);
    assign count_d = count_q + CNT_W'(accept) - CNT_W'(retire);

    load_data_slicer u_slicer (
        .uop_i    (head_entry.uop),
        .signed_i (head_entry.signed_load),
        .offset_i (head_entry.offset),
        .data_i   (head_entry.data),
        .data_o   (sliced_data)
    );

    always_comb begin
        data_valid_d  = retire;
        data_loaded_d = data_loaded_q;
        misaligned_d  = misaligned_q;
        illegal_d     = illegal_q;
        if (retire) begin
            misaligned_d  = head_entry.misaligned;
            illegal_d     = head_entry.illegal;
            data_loaded_d = (head_entry.misaligned | head_entry.illegal) ? '0 : sliced_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            data_loaded_q <= '0;
            data_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            data_loaded_q <= data_loaded_d;
            data_valid_q  <= data_valid_d;
            misaligned_q  <= misaligned_d;
            illegal_q     <= illegal_d;
        end
    end

    assign data_loaded_o    = data_loaded_q;
    assign data_valid_o     = data_valid_q;
    assign misaligned_o     = misaligned_q;
    assign illegal_access_o = illegal_q;
    assign idle_o           = (count_q == '0) & ~data_valid_q;

endmodule

// File: tb/tb_load_queue_unit.sv
module tb_load_queue_unit;
    import apogeo_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         stall = 1'b0;
    logic         privilege = 1'b0;
    logic         valid_op = 1'b0;
    ldu_uop_t     operation;
    data_word_t   address = '0;
    logic         ready;
    logic         fwd_match = 1'b0;
    data_word_t   fwd_data = '0;
    store_width_t load_size;
    logic         buffer_wait = 1'b0;
    data_word_t   data_loaded;
    logic         data_valid, misaligned, illegal_access, idle;

    always #5 clk = ~clk;

    load_interface lc ();

    load_queue_unit #(.DEPTH(4)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .stall_i           (stall),
        .privilege_i       (privilege),
        .valid_operation_i (valid_op),
        .operation_i       (operation),
        .load_address_i    (address),
        .ready_o           (ready),
        .load_channel      (lc),
        .foward_match_i    (fwd_match),
        .foward_data_i     (fwd_data),
        .load_size_o       (load_size),
        .buffer_wait_i     (buffer_wait),
        .data_loaded_o     (data_loaded),
        .data_valid_o      (data_valid),
        .misaligned_o      (misaligned),
        .illegal_access_o  (illegal_access),
        .idle_o            (idle)
    );

    typedef struct {
        data_word_t data;
        logic       mis;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   req_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input data_word_t d, input logic m, input logic i);
        exp_t e;
        e.data = d;
        e.mis  = m;
        e.ill  = i;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input ldu_op_t op, input logic sgn, input data_word_t addr,
                         input logic priv, input logic fm, input data_word_t fd,
                         output logic req, output logic rdy);
        valid_op              = 1'b1;
        operation.uop         = op;
        operation.signed_load = sgn;
        address               = addr;
        privilege             = priv;
        fwd_match             = fm;
        fwd_data              = fd;
        #1;
        req = lc.request;
        rdy = ready;
        tick();
        valid_op  = 1'b0;
        fwd_match = 1'b0;
    endtask

    task automatic respond(input data_word_t d);
        lc.valid = 1'b1;
        lc.data  = d;
        tick();
        lc.valid = 1'b0;
    endtask

    // Scoreboard side: every retire pulse is compared against the oldest
    // expectation pushed when the matching op was driven.
    always @(negedge clk) begin
        if (lc.request) req_seen++;
        if (rst_n && data_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'b0, data_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", data_loaded, mon_e.data);
                check("sb_misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
                check("sb_illegal", {31'b0, illegal_access}, {31'b0, mon_e.ill});
            end
        end
    end

    initial begin
        logic req, rdy;
        int   base;
        data_word_t d [4];

        operation.uop         = LDW;
        operation.signed_load = 1'b0;
        lc.valid              = 1'b0;
        lc.data               = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_valid", {31'b0, data_valid}, 32'd0);
        check("rst_data", data_loaded, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_ill", {31'b0, illegal_access}, 32'd0);
        check("rst_ready", {31'b0, ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Combinational load size
        operation.uop = LDH;
        #1 check("size_half", {30'b0, load_size}, {30'b0, WIDTH_HALF});
        operation.uop = LDB;
        #1 check("size_byte", {30'b0, load_size}, {30'b0, WIDTH_BYTE});
        tick();

        // Signed byte from memory, one cycle after the response
        push(32'hFFFF_FF80, 1'b0, 1'b0);
        issue(LDB, 1'b1, 32'h0000_1003, 1'b0, 1'b0, '0, req, rdy);
        check("t1_ready", {31'b0, rdy}, 32'd1);
        check("t1_req", {31'b0, req}, 32'd1);
        respond(32'h80AA_BBCC);
        check("t1_latency", {31'b0, data_valid}, 32'd1);
        check("t1_data", data_loaded, 32'hFFFF_FF80);
        check("t1_busy", {31'b0, idle}, 32'd0);
        tick();
        check("t1_pulse_end", {31'b0, data_valid}, 32'd0);
        check("t1_idle", {31'b0, idle}, 32'd1);

        // Fill the queue, then free one slot
        for (int i = 0; i < 4; i++) begin
            d[i] = 32'h1111_0000 + 32'(i);
            push(d[i], 1'b0, 1'b0);
            issue(LDW, 1'b0, 32'h0000_0100 + 32'(4 * i), 1'b0, 1'b0, '0, req, rdy);
            check("t2_ready", {31'b0, rdy}, 32'd1);
            check("t2_req", {31'b0, req}, 32'd1);
        end
        valid_op      = 1'b1;
        operation.uop = LDW;
        address       = 32'h0000_0200;
        #1;
        check("t2_full_ready", {31'b0, ready}, 32'd0);
        check("t2_full_req", {31'b0, lc.request}, 32'd0);
        valid_op = 1'b0;
        lc.valid = 1'b1;
        lc.data  = d[0];
        #1 check("t2_same_cycle_ready", {31'b0, ready}, 32'd0);
        tick();
        lc.valid = 1'b0;
        check("t2_ready_rises", {31'b0, ready}, 32'd1);
        for (int i = 1; i < 4; i++) respond(d[i]);
        tick();

        // Younger exception / forward entries wait behind an older memory load
        base = req_seen;
        push(32'hCAFE_F00D, 1'b0, 1'b0);
        issue(LDW, 1'b0, 32'h0000_0300, 1'b0, 1'b0, '0, req, rdy);
        check("t3_mem_req", {31'b0, req}, 32'd1);
        push(32'h0000_0000, 1'b1, 1'b0);
        issue(LDW, 1'b0, 32'h0000_2002, 1'b0, 1'b0, '0, req, rdy);
        check("t3_mis_req", {31'b0, req}, 32'd0);
        push(32'h0000_1234, 1'b0, 1'b0);
        issue(LDH, 1'b0, 32'h0000_0400, 1'b0, 1'b1, 32'h0000_1234, req, rdy);
`ifdef LOAD_QUEUE_FORWARDING_EN
        check("t3_fwd_req", {31'b0, req}, 32'd0);
`else
        check("t3_fwd_req", {31'b0, req}, 32'd1);
`endif
        tick();
        check("t3_blocked", {31'b0, data_valid}, 32'd0);
`ifdef LOAD_QUEUE_FORWARDING_EN
        check("t3_req_count", 32'(req_seen - base), 32'd1);
`else
        check("t3_req_count", 32'(req_seen - base), 32'd2);
`endif
        respond(32'hCAFE_F00D);
        check("t3_first", data_loaded, 32'hCAFE_F00D);
        tick();
        check("t3_mis_valid", {31'b0, data_valid}, 32'd1);
        check("t3_mis_flag", {31'b0, misaligned}, 32'd1);
        check("t3_mis_data", data_loaded, 32'd0);
`ifdef LOAD_QUEUE_FORWARDING_EN
        tick();
`else
        respond(32'h0000_1234);
`endif
        check("t3_fwd_valid", {31'b0, data_valid}, 32'd1);
        check("t3_fwd_data", data_loaded, 32'h0000_1234);
        tick();

        // Stall while responses arrive; nothing retires until release
        push(32'h0BAD_0001, 1'b0, 1'b0);
        issue(LDW, 1'b0, 32'h0000_0500, 1'b0, 1'b0, '0, req, rdy);
        push(32'h0BAD_0002, 1'b0, 1'b0);
        issue(LDW, 1'b0, 32'h0000_0504, 1'b0, 1'b0, '0, req, rdy);
        stall = 1'b1;
        respond(32'h0BAD_0001);
        check("t4_stall_a", {31'b0, data_valid}, 32'd0);
        check("t4_hold", data_loaded, 32'h0000_1234);
        push(32'h0000_0033, 1'b0, 1'b0);
        issue(LDB, 1'b0, 32'h0000_0601, 1'b0, 1'b0, '0, req, rdy);
        check("t4_stall_accept", {31'b0, rdy}, 32'd1);
        check("t4_stall_req", {31'b0, req}, 32'd1);
        check("t4_stall_b", {31'b0, data_valid}, 32'd0);
        respond(32'h0BAD_0002);
        check("t4_stall_c", {31'b0, data_valid}, 32'd0);
        stall = 1'b0;
        tick();
        check("t4_release_a", {31'b0, data_valid}, 32'd1);
        check("t4_data_a", data_loaded, 32'h0BAD_0001);
        tick();
        check("t4_release_b", {31'b0, data_valid}, 32'd1);
        check("t4_data_b", data_loaded, 32'h0BAD_0002);
        respond(32'h1122_3344);
        check("t4_byte_unsigned", data_loaded, 32'h0000_0033);
        tick();

        // Private region: user mode faults at once, machine mode goes to memory
        push(32'h0000_0000, 1'b0, 1'b1);
        issue(LDW, 1'b0, 32'h8000_0010, 1'b0, 1'b0, '0, req, rdy);
        check("t5_ill_req", {31'b0, req}, 32'd0);
        check("t5_ill_valid", {31'b0, data_valid}, 32'd1);
        check("t5_ill_flag", {31'b0, illegal_access}, 32'd1);
        check("t5_ill_data", data_loaded, 32'd0);
        push(32'h5555_AAAA, 1'b0, 1'b0);
        issue(LDW, 1'b0, 32'h8000_0020, 1'b1, 1'b0, '0, req, rdy);
        check("t5_mach_req", {31'b0, req}, 32'd1);
        respond(32'h5555_AAAA);
        check("t5_mach_ill", {31'b0, illegal_access}, 32'd0);
        tick();

        // Reset with two loads outstanding; the late response is dropped
        issue(LDW, 1'b0, 32'h0000_0700, 1'b0, 1'b0, '0, req, rdy);
        issue(LDW, 1'b0, 32'h0000_0704, 1'b0, 1'b0, '0, req, rdy);
        check("t6_busy", {31'b0, idle}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_idle", {31'b0, idle}, 32'd1);
        check("t6_rst_valid", {31'b0, data_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        respond(32'hDEAD_BEEF);
        check("t6_stale_valid", {31'b0, data_valid}, 32'd0);
        check("t6_stale_idle", {31'b0, idle}, 32'd1);
        tick();
        check("t6_stale_valid2", {31'b0, data_valid}, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_queue_unit.md
LOAD_QUEUE_UNIT -- requirements
Module: load_queue_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding loads; power of two, 2..16.
REQ-002 SHALL have ports clk_i in 1, single clock; rst_n_i in 1, reset asynchronous active-low.
REQ-003 SHALL have ports stall_i in 1 (pipeline stall) and privilege_i in 1 (1 = MACHINE).
REQ-004 SHALL have ports valid_operation_i in 1, operation_i in ldu_uop_t and load_address_i in data_word_t.
REQ-005 SHALL have port ready_o out 1, accept allowed this cycle.
REQ-006 SHALL have load_channel as load_interface.master (request, address, valid, data).
REQ-007 SHALL have ports foward_match_i in 1, foward_data_i in data_word_t and load_size_o out store_width_t.
REQ-008 SHALL have port buffer_wait_i in 1, store buffer draining.
REQ-009 SHALL have outputs data_loaded_o data_word_t, data_valid_o 1, misaligned_o 1, illegal_access_o 1 and idle_o 1.

Function
REQ-010 SHALL accept an op when valid_operation_i & ready_o; ready_o = (count < DEPTH) & !buffer_wait_i; a retire in the same cycle SHALL NOT raise ready_o when full.
REQ-011 SHALL allocate on accept the entry at tail: uop, signed_load, address[1:0], flags, done, data.
REQ-012 SHALL check misalignment on accept: LDB never; LDH addr[0]; LDW addr[1:0]!=0.
REQ-013 SHALL flag illegal on accept when the address is in [PRIVATE_REGION_START, PRIVATE_REGION_END] and privilege_i=0.
REQ-014 SHALL mark an accepted exception entry done with data 0 and SHALL NOT issue a memory request for it.
REQ-015 SHALL, on an accepted forward hit (foward_match_i=1), store the forwarded data, mark the entry done and issue no request.
REQ-016 SHALL otherwise pulse load_channel.request for one cycle in the accept cycle, with address = load_address_i.
REQ-017 SHALL drive load_size_o combinationally from operation_i.uop.
REQ-018 SHALL treat memory responses as in-order: each load_channel.valid fills the oldest memory-pending entry; a valid with none pending SHALL be ignored.
REQ-019 SHALL retire the head entry when done & !stall_i, driving registered outputs on the next edge.
REQ-020 SHALL make latency accept-to-data_valid_o 1 cycle for forward/exception at head, and response-to-data_valid_o 1 cycle for memory at head.
REQ-021 SHALL slice data at retire: LDB byte[offset], LDH half[offset[1]], sign/zero extended per signed_load; LDW passthrough.
REQ-022 SHALL pulse data_valid_o for 1 cycle per retire, with misaligned_o/illegal_access_o valid alongside and data_loaded_o=0 on exception.
REQ-023 SHALL, while stall_i=1, hold all outputs, retire nothing, and still accept ops and capture responses into entries; no data is lost.
REQ-024 SHALL keep results in program order, even when a younger forward/exception entry completes before an older memory entry.
REQ-025 SHALL wrap the head, tail and memory-pending pointers modulo DEPTH.
REQ-026 SHALL drive idle_o=1 only when count=0 and no retire is in flight.

Reset
REQ-027 SHALL on rst_n_i=0 clear pointers and count, invalidate entries, and set data_valid_o, misaligned_o, illegal_access_o and data_loaded_o to 0 and idle_o to 1.
REQ-028 SHALL on reset mid-operation discard all entries; memory responses after reset SHALL be ignored per REQ-018.

Configuration
REQ-029 SHALL honour macro LOAD_QUEUE_FORWARDING_EN: when defined, REQ-015 is active; when undefined, foward_match_i and foward_data_i are ignored and every legal op issues a memory request.

Structure
REQ-030 SHALL define load_queue_entry_t in apogeo_pkg; ldu_uop_t and store_width_t SHALL stay in the existing packages.
REQ-031 SHALL place slicing/extension in combinational sub-module load_data_slicer.

Verification
REQ-032 SHALL cover: LDB signed at 0x1003, memory returns 0x80AABBCC -> data_loaded_o=0xFFFFFF80, 1 cycle after valid.
REQ-033 SHALL cover: 4 LDW back-to-back with DEPTH=4, no responses -> ready_o=0 on the 5th; after one response ready_o rises the next cycle.
REQ-034 SHALL cover: LDW at 0x2002 then LDH forward hit 0x1234 while the older LDW is pending -> misaligned retire first, then 0x00001234, no requests.
REQ-035 SHALL cover: stall_i high 3 cycles while 2 responses arrive -> no data_valid_o; after release, 2 consecutive in-order pulses.
REQ-036 SHALL cover: private-region load with privilege_i=0 -> illegal_access_o=1, data 0, no request; rst_n_i low with 2 pending -> idle_o=1, stale response ignored.
